// File: rtl/multi_channel_collector.sv
// rtl/multi_channel_collector.sv - per-channel FIFOs drained round-robin into one tagged ready/valid stream
module multi_channel_collector #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  input  logic                      out_ready,
  output logic [NUM_CH-1:0]         ovf,
  input  logic                      clr_ovf
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q  [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q [NUM_CH];
  logic [PTR_W-1:0]  rptr_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];

  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] push_ok;
  logic [NUM_CH-1:0] ovf_set;

  logic              out_free;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  assign out_free = !out_valid_q || out_ready;

  // Round-robin search begins just after the most recent grant.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = last_grant_q;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = (int'(last_grant_q) + off) % NUM_CH;
      if (!grant_vld && not_empty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
  end

  // A full FIFO still accepts a push when it is popped on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      not_empty[i] = (cnt_q[i] != '0);
      full[i]      = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
      pop[i]       = out_free && grant_vld && (grant_idx == CH_W'(i));
      push_ok[i]   = ch_valid[i] && (!full[i] || pop[i]);
      ovf_set[i]   = ch_valid[i] && full[i] && !pop[i];
      cnt_d[i]     = cnt_q[i];
      if (push_ok[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!push_ok[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (out_free) begin
      if (grant_vld) begin
        out_valid_d  = 1'b1;
        out_data_d   = mem_q[grant_idx][rptr_q[grant_idx]];
        out_ch_d     = grant_idx;
        last_grant_d = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    ovf_d = (clr_ovf ? '0 : ovf_q) | ovf_set;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_ok[i]) begin
        mem_q[i][wptr_q[i]] <= ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      ovf_q        <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_ok[i]) wptr_q[i] <= wptr_q[i] + PTR_W'(1);
        if (pop[i])     rptr_q[i] <= rptr_q[i] + PTR_W'(1);
        cnt_q[i] <= cnt_d[i];
      end
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign ovf       = ovf_q;

endmodule
